// File: rtl/div_seq_ctrl_if.sv
// Request/result and shared add/subtract unit signals of the RV32M divide sequencer.
// The slave modport is the sequencer; the master modport is the core plus adder side.
interface div_seq_ctrl_if #(
  parameter int XLEN = 32
);
  logic            start_i;
  logic [1:0]      op_i;
  logic [XLEN-1:0] rs1_i;
  logic [XLEN-1:0] rs2_i;
  logic            busy_o;
  logic            valid_o;
  logic [XLEN-1:0] result_o;
  logic [XLEN-1:0] as_a_o;
  logic [XLEN-1:0] as_b_o;
  logic            as_cin_o;
  logic [XLEN-1:0] as_result_i;
  logic            as_cout_i;

  modport slave (
    input  start_i, op_i, rs1_i, rs2_i, as_result_i, as_cout_i,
    output busy_o, valid_o, result_o, as_a_o, as_b_o, as_cin_o
  );

  modport master (
    output start_i, op_i, rs1_i, rs2_i, as_result_i, as_cout_i,
    input  busy_o, valid_o, result_o, as_a_o, as_b_o, as_cin_o
  );
endinterface

// File: rtl/div_seq_ctrl.sv
// Fixed-latency DIV/DIVU/REM/REMU sequencer: negate operands, 32 restoring steps,
// fix result signs, all through one external add/subtract unit. Only XLEN=32 is supported.
module div_seq_ctrl #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  div_seq_ctrl_if.slave   bus
);

  typedef enum logic [2:0] {
    IDLE,
    NEG_A,
    NEG_B,
    ITER,
    NEG_Q,
    NEG_R,
    DONE
  } state_t;

  state_t          state;
  state_t          state_next;

  logic            is_rem;
  logic            sa;
  logic            sb;
  logic            dz;
  logic [XLEN-1:0] q;
  logic [XLEN-1:0] d;
  logic [XLEN-1:0] r;
  logic [4:0]      step;
  logic [XLEN-1:0] result;

  logic [XLEN-1:0] trial;
  logic            take;
  logic [XLEN-1:0] as_a;
  logic [XLEN-1:0] as_b;
  logic            as_cin;

  // R[31] set means the shifted-in trial is really 33 bits wide and always exceeds D
  assign trial = {r[XLEN-2:0], q[XLEN-1]};
  assign take  = r[XLEN-1] | ~bus.as_cout_i;

  always_comb begin
    state_next = state;
    as_a       = '0;
    as_b       = '0;
    as_cin     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start_i) state_next = NEG_A;
      end
      NEG_A: begin
        as_b       = q;
        as_cin     = 1'b1;
        state_next = NEG_B;
      end
      NEG_B: begin
        as_b       = d;
        as_cin     = 1'b1;
        state_next = ITER;
      end
      ITER: begin
        as_a   = trial;
        as_b   = d;
        as_cin = 1'b1;
        if (step == 5'd31) state_next = NEG_Q;
      end
      NEG_Q: begin
        as_b       = q;
        as_cin     = 1'b1;
        state_next = NEG_R;
      end
      NEG_R: begin
        as_b       = r;
        as_cin     = 1'b1;
        state_next = DONE;
      end
      DONE: begin
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state  <= IDLE;
      is_rem <= 1'b0;
      sa     <= 1'b0;
      sb     <= 1'b0;
      dz     <= 1'b0;
      q      <= '0;
      d      <= '0;
      r      <= '0;
      step   <= '0;
      result <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (bus.start_i) begin
            is_rem <= bus.op_i[1];
            sa     <= bus.rs1_i[XLEN-1] & ~bus.op_i[0];
            sb     <= bus.rs2_i[XLEN-1] & ~bus.op_i[0];
            dz     <= (bus.rs2_i == '0);
            q      <= bus.rs1_i;
            d      <= bus.rs2_i;
            r      <= '0;
            step   <= '0;
          end
        end
        NEG_A: begin
          if (sa) q <= bus.as_result_i;
        end
        NEG_B: begin
          if (sb) d <= bus.as_result_i;
        end
        ITER: begin
          r    <= take ? bus.as_result_i : trial;
          q    <= {q[XLEN-2:0], take};
          step <= step + 5'd1;
        end
        NEG_Q: begin
          // a zero divisor keeps the all-ones quotient regardless of operand signs
          if ((sa ^ sb) & ~dz) q <= bus.as_result_i;
        end
        NEG_R: begin
          if (sa) r <= bus.as_result_i;
          result <= is_rem ? (sa ? bus.as_result_i : r) : q;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy_o   = (state != IDLE);
  assign bus.valid_o  = (state == DONE);
  assign bus.result_o = result;
  assign bus.as_a_o   = as_a;
  assign bus.as_b_o   = as_b;
  assign bus.as_cin_o = as_cin;

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Directed bench for div_seq_ctrl: table of divide vectors plus busy, back-to-back
// and reset-abort sequences, with a behavioural add/subtract unit.
module tb_div_seq_ctrl;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;

  div_seq_ctrl_if #(.XLEN(32)) bus ();

  div_seq_ctrl #(.XLEN(32)) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  logic [32:0] add_sum;
  assign add_sum         = {1'b0, bus.as_a_o} + {1'b0, bus.as_b_o};
  assign bus.as_result_i = bus.as_cin_o ? (bus.as_a_o - bus.as_b_o) : add_sum[31:0];
  assign bus.as_cout_i   = bus.as_cin_o ? (bus.as_a_o < bus.as_b_o) : add_sum[32];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  vec_t vecs[14];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // Issues one request and observes cycles C1..C40; inject>0 pulses a second start at that cycle
  task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                               input int inject, output logic [31:0] res, output int vcycle,
                               output int bcnt, output int vcnt, output logic drive_ok,
                               output logic [31:0] res_end);
    @(negedge clk);
    bus.start_i = 1'b1;
    bus.op_i    = op;
    bus.rs1_i   = a;
    bus.rs2_i   = b;
    @(posedge clk);
    vcycle   = 0;
    bcnt     = 0;
    vcnt     = 0;
    res      = '0;
    drive_ok = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (bus.busy_o) bcnt++;
      if (bus.valid_o) begin
        vcnt++;
        if (vcycle == 0) begin
          vcycle = n;
          res    = bus.result_o;
          if (bus.as_a_o != 0 || bus.as_b_o != 0 || bus.as_cin_o) drive_ok = 1'b0;
        end
      end
      if (n == 1) begin
        bus.start_i = 1'b0;
        bus.op_i    = ~op;
        bus.rs1_i   = $urandom;
        bus.rs2_i   = $urandom;
      end
      if (inject > 0 && n == inject) begin
        bus.start_i = 1'b1;
        bus.op_i    = OP_DIVU;
        bus.rs1_i   = 32'd1000;
        bus.rs2_i   = 32'd3;
      end
      if (inject > 0 && n == inject + 1) bus.start_i = 1'b0;
    end
    res_end = bus.result_o;
  endtask

  logic [31:0] res;
  logic [31:0] res_end;
  int          vcycle;
  int          bcnt;
  int          vcnt;
  logic        drive_ok;
  int          valid_at[$];

  initial begin
    n_checks = 0;
    n_pass   = 0;

    vecs[0]  = '{"divu_100_7",      OP_DIVU, 32'd100,        32'd7,          32'd14};
    vecs[1]  = '{"remu_100_7",      OP_REMU, 32'd100,        32'd7,          32'd2};
    vecs[2]  = '{"div_m7_2",        OP_DIV,  32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD};
    vecs[3]  = '{"rem_m7_2",        OP_REM,  32'hFFFFFFF9,   32'd2,          32'hFFFFFFFF};
    vecs[4]  = '{"div_7_m2",        OP_DIV,  32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD};
    vecs[5]  = '{"rem_7_m2",        OP_REM,  32'd7,          32'hFFFFFFFE,   32'd1};
    vecs[6]  = '{"div_5_0",         OP_DIV,  32'd5,          32'd0,          32'hFFFFFFFF};
    vecs[7]  = '{"div_m5_0",        OP_DIV,  32'hFFFFFFFB,   32'd0,          32'hFFFFFFFF};
    vecs[8]  = '{"rem_m5_0",        OP_REM,  32'hFFFFFFFB,   32'd0,          32'hFFFFFFFB};
    vecs[9]  = '{"divu_0_0",        OP_DIVU, 32'd0,          32'd0,          32'hFFFFFFFF};
    vecs[10] = '{"divu_big_msb",    OP_DIVU, 32'hFFFFFFFF,   32'h80000000,   32'd1};
    vecs[11] = '{"remu_big_msb",    OP_REMU, 32'hFFFFFFFF,   32'h80000000,   32'h7FFFFFFF};
    vecs[12] = '{"div_overflow",    OP_DIV,  32'h80000000,   32'hFFFFFFFF,   32'h80000000};
    vecs[13] = '{"rem_overflow",    OP_REM,  32'h80000000,   32'hFFFFFFFF,   32'd0};

    rst_n       = 1'b0;
    bus.start_i = 1'b0;
    bus.op_i    = '0;
    bus.rs1_i   = '0;
    bus.rs2_i   = '0;
    #12;
    checkOutput("reset_busy",   {31'd0, bus.busy_o},   32'd0);
    checkOutput("reset_valid",  {31'd0, bus.valid_o},  32'd0);
    checkOutput("reset_result", bus.result_o,          32'd0);
    checkOutput("reset_as_a",   bus.as_a_o,            32'd0);
    checkOutput("reset_as_b",   bus.as_b_o,            32'd0);
    checkOutput("reset_as_cin", {31'd0, bus.as_cin_o}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, 0, res, vcycle, bcnt, vcnt, drive_ok, res_end);
      checkOutput({vecs[i].name, "_result"}, res, vecs[i].exp);
      checkOutput({vecs[i].name, "_valid_cycle"}, vcycle, 32'd37);
      checkOutput({vecs[i].name, "_busy_cycles"}, bcnt, 32'd37);
      checkOutput({vecs[i].name, "_valid_width"}, vcnt, 32'd1);
      checkOutput({vecs[i].name, "_done_adder_idle"}, {31'd0, drive_ok}, 32'd1);
      checkOutput({vecs[i].name, "_result_held"}, res_end, vecs[i].exp);
    end

    // start pulsed at C10 while busy must be dropped, not queued
    applyStimulus(OP_DIVU, 32'd100, 32'd7, 10, res, vcycle, bcnt, vcnt, drive_ok, res_end);
    checkOutput("ignore_result",      res,     32'd14);
    checkOutput("ignore_valid_cycle", vcycle,  32'd37);
    checkOutput("ignore_busy_cycles", bcnt,    32'd37);
    checkOutput("ignore_result_held", res_end, 32'd14);

    // start held high: results at C37 and C75
    @(negedge clk);
    bus.start_i = 1'b1;
    bus.op_i    = OP_DIVU;
    bus.rs1_i   = 32'd100;
    bus.rs2_i   = 32'd7;
    @(posedge clk);
    bcnt = 0;
    res  = '0;
    valid_at.delete();
    for (int n = 1; n <= 80; n++) begin
      @(negedge clk);
      if (bus.busy_o) bcnt++;
      if (bus.valid_o) begin
        valid_at.push_back(n);
        if (bus.result_o != 32'd14) res = bus.result_o;
      end
      if (n == 76) bus.start_i = 1'b0;
    end
    checkOutput("b2b_valid_count", valid_at.size(), 32'd2);
    if (valid_at.size() >= 2) begin
      checkOutput("b2b_first_valid",  valid_at[0], 32'd37);
      checkOutput("b2b_second_valid", valid_at[1], 32'd75);
    end
    checkOutput("b2b_busy_cycles", bcnt, 32'd74);
    checkOutput("b2b_bad_result",  res,  32'd0);
    for (int k = 0; k < 60 && bus.busy_o; k++) @(negedge clk);
    checkOutput("b2b_back_idle", {31'd0, bus.busy_o}, 32'd0);

    // reset asserted mid-iteration aborts immediately
    @(negedge clk);
    bus.start_i = 1'b1;
    bus.op_i    = OP_DIVU;
    bus.rs1_i   = 32'd1000;
    bus.rs2_i   = 32'd3;
    @(posedge clk);
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (n == 1) bus.start_i = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    checkOutput("abort_busy",   {31'd0, bus.busy_o},   32'd0);
    checkOutput("abort_valid",  {31'd0, bus.valid_o},  32'd0);
    checkOutput("abort_result", bus.result_o,          32'd0);
    checkOutput("abort_as_a",   bus.as_a_o,            32'd0);
    checkOutput("abort_as_b",   bus.as_b_o,            32'd0);
    checkOutput("abort_as_cin", {31'd0, bus.as_cin_o}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    vcnt  = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (bus.valid_o || bus.busy_o) vcnt++;
    end
    checkOutput("abort_no_pulse", vcnt, 32'd0);

    applyStimulus(OP_DIVU, 32'd9, 32'd3, 0, res, vcycle, bcnt, vcnt, drive_ok, res_end);
    checkOutput("post_reset_result",      res,    32'd3);
    checkOutput("post_reset_valid_cycle", vcycle, 32'd37);
    checkOutput("post_reset_busy_cycles", bcnt,   32'd37);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
